// File: rtl/parity_pkg.sv
// Shared constants and helpers for the parity generator/checker slice.
//   PAR_EVEN / PAR_ODD : parity sense encodings (value XORed onto the data reduction)
//   par_calc           : width-generic parity helper; callers zero-extend their word
//                        into PAR_MAX_W bits (zero padding does not change the XOR)
package parity_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PAR_MAX_W = 1024;

  function automatic logic par_calc(input logic [PAR_MAX_W-1:0] data, input logic sense);
    return (^data) ^ sense;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational XOR reduction over a WIDTH-bit word.
//   data_i : input word
//   par_o  : XOR of all bits of data_i (1 when an odd number of bits are set)
module parity_tree #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/parity_gen_chk_pipe.sv
// Pipelined even/odd parity generator and checker with a single output register.
// Each accepted word is presented one cycle later with its generated parity and, in
// check mode, a mismatch flag. A saturating error counter and a sticky flag track
// flagged words for status readback.
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_data, in_par, chk_en qualified by accept
//   out_valid/out_ready : output handshake; out_data, out_par, out_err
//   clr_err             : clears err_cnt/err_sticky (a same-cycle error still counts)
//   err_cnt, err_sticky : saturating error count and sticky error flag
module parity_gen_chk_pipe
  import parity_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ODD       = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_par,
  input  logic                 chk_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_par,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky
);

  localparam logic Sense = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic                 xor_all;
  logic                 gen;
  logic                 mismatch;
  logic                 accept;
  logic                 err_hit;

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic                 out_par_q, out_par_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  parity_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .data_i(in_data),
    .par_o (xor_all)
  );

  assign gen      = xor_all ^ Sense;
  assign mismatch = chk_en & (gen != in_par);

  // One output register and no skid buffer: space exists only if it is empty or draining.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  // Gating with accept keeps idle (possibly X) inputs out of the state.
  assign err_hit  = accept & mismatch;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_par_d   = gen;
      out_err_d   = mismatch;
    end else if (out_ready) begin
      // Drain: data registers keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      // Clear first, then count an error arriving in the same cycle.
      err_cnt_d    = err_hit ? ERR_CNT_W'(1) : '0;
      err_sticky_d = err_hit;
    end else if (err_hit) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_par_q    <= 1'b0;
      out_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_par_q    <= out_par_d;
      out_err_q    <= out_err_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_par    = out_par_q;
  assign out_err    = out_err_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

endmodule
